cdb_arbiter: RTL and testbench

Round-robin arbiter for the common data bus (CDB). Each functional unit (ALU, MUL, LSU, branch) presents one completed result (ROB tag plus value). The arbiter grants at most one result per cycle and broadcasts it from a registered CDB stage to the reservation stations, ROB and RAT. It sits between the functional-unit outputs and the writeback/wakeup network, downstream of dispatch.

---
 rtl/cdb_pkg.sv | 18 +
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter_rr.sv | 36 +++
 rtl/cdb_arbiter.sv | 69 ++++++
 tb/tb_cdb_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus arbiter: default widths, bus payload, requester indices.
package cdb_pkg;

    localparam int unsigned CDB_TAG_W  = 5;
    localparam int unsigned CDB_DATA_W = 32;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MUL = 1;
    localparam int unsigned REQ_LSU = 2;
    localparam int unsigned REQ_BR  = 3;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit request bundle and registered CDB broadcast between requesters and the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][TAG_W-1:0]  req_tag;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [DATA_W-1:0]            cdb_data;
    logic [IDX_W-1:0]             cdb_src;

    // Requester side: functional units and CDB consumers.
    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N-1.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int unsigned IDX_W = $clog2(N);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Extra sum bit keeps ptr+k exact so the wrap works for non-power-of-2 N.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of one FU result per cycle into a registered broadcast stage.
// Optional contention counter stat_conflict when CDB_STATS_EN is defined.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned TAG_W  = CDB_TAG_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    cdb_arbiter_if.slave bus
`ifdef CDB_STATS_EN
    ,
    output logic [31:0] stat_conflict
`endif
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] ptr;
    logic             any_gnt;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = (rst || flush) ? '0 : gnt;
    assign any_gnt       = |bus.req_ready;

    // Priority pointer and broadcast register; a flush leaves an already visible broadcast alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cdb_valid <= 1'b0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
            bus.cdb_src   <= '0;
            ptr           <= '0;
        end else if (flush) begin
            bus.cdb_valid <= 1'b0;
            ptr           <= '0;
        end else begin
            bus.cdb_valid <= any_gnt;
            if (any_gnt) begin
                bus.cdb_tag  <= bus.req_tag[gnt_idx];
                bus.cdb_data <= bus.req_data[gnt_idx];
                bus.cdb_src  <= gnt_idx;
                ptr          <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end
    end

`ifdef CDB_STATS_EN
    // Saturating count of cycles with two or more competing requesters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conflict <= '0;
        end else if (!flush && ($countones(bus.req_valid) >= 2) && (stat_conflict != '1)) begin
            stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed cycles push expectations, a negedge monitor checks them.
module tb_cdb_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        logic [N_REQ-1:0]  ready;
        logic              cv;
        logic              chk_pay;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [1:0]        src;
        logic              chk_stat;
        logic [31:0]       stat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    cdb_arbiter_if #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

`ifdef CDB_STATS_EN
    logic [31:0] stat_conflict;
`endif

    cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef CDB_STATS_EN
        ,
        .stat_conflict (stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("req_ready", 32'(bus.req_ready), 32'(e.ready));
            chk("cdb_valid", 32'(bus.cdb_valid), 32'(e.cv));
            if (e.cv || e.chk_pay) begin
                chk("cdb_tag",  32'(bus.cdb_tag),  32'(e.tag));
                chk("cdb_data", bus.cdb_data,      e.data);
                chk("cdb_src",  32'(bus.cdb_src),  32'(e.src));
            end
`ifdef CDB_STATS_EN
            if (e.chk_stat) begin
                chk("stat_conflict", stat_conflict, e.stat);
            end
`endif
        end
    end

    task automatic cyc_s(input logic r, input logic f, input logic [3:0] v,
                         input logic [3:0] rdy, input logic cv, input logic cp,
                         input logic [4:0] tag, input logic [31:0] data, input logic [1:0] src,
                         input logic cs, input logic [31:0] st);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        flush = f;
        bus.req_valid = v;
        e.ready = rdy; e.cv = cv; e.chk_pay = cp; e.tag = tag; e.data = data;
        e.src = src; e.chk_stat = cs; e.stat = st;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic f, input logic [3:0] v,
                       input logic [3:0] rdy, input logic cv, input logic cp,
                       input logic [4:0] tag, input logic [31:0] data, input logic [1:0] src);
        cyc_s(r, f, v, rdy, cv, cp, tag, data, src, 1'b0, 32'd0);
    endtask

    task automatic set_default_payload();
        for (int i = 0; i < int'(N_REQ); i++) begin
            bus.req_tag[i]  = 5'(16 + i);
            bus.req_data[i] = 32'hA000_0000 + 32'(i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        set_default_payload();

        // Reset dominates flush and valid requests.
        cyc(1, 1, 4'b1111, 4'b0000, 0, 1, 5'd0, 32'h0, 2'd0);
        cyc(1, 0, 4'b1111, 4'b0000, 0, 1, 5'd0, 32'h0, 2'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0000, 4'b0000, 0, 1, 5'd0, 32'h0, 2'd0);

        // Lone requester 2, then payload holds after the broadcast.
        bus.req_tag[2]  = 5'd7;
        bus.req_data[2] = 32'hDEAD_BEEF;
        cyc(0, 0, 4'b0100, 4'b0100, 0, 1, 5'd0, 32'h0, 2'd0);
        cyc(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd7, 32'hDEAD_BEEF, 2'd2);
        cyc(0, 0, 4'b0000, 4'b0000, 0, 1, 5'd7, 32'hDEAD_BEEF, 2'd2);
        set_default_payload();

        // All four continuously from reset: 0,1,2,3,0.
        cyc(1, 0, 4'b1111, 4'b0000, 0, 0, 5'd0, 32'h0, 2'd0);
        cyc(0, 0, 4'b1111, 4'b0001, 0, 1, 5'd0, 32'h0, 2'd0);
        cyc(0, 0, 4'b1111, 4'b0010, 1, 1, 5'd16, 32'hA000_0000, 2'd0);
        cyc(0, 0, 4'b1111, 4'b0100, 1, 1, 5'd17, 32'hA000_0001, 2'd1);
        cyc(0, 0, 4'b1111, 4'b1000, 1, 1, 5'd18, 32'hA000_0002, 2'd2);
        cyc(0, 0, 4'b1111, 4'b0001, 1, 1, 5'd19, 32'hA000_0003, 2'd3);

        // Requesters 1 and 3: ptr reaches 2, so 3 then wrap to 1.
        cyc(0, 0, 4'b1010, 4'b0010, 1, 1, 5'd16, 32'hA000_0000, 2'd0);
        cyc(0, 0, 4'b1010, 4'b1000, 1, 1, 5'd17, 32'hA000_0001, 2'd1);
        cyc(0, 0, 4'b1010, 4'b0010, 1, 1, 5'd19, 32'hA000_0003, 2'd3);
        cyc(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd17, 32'hA000_0001, 2'd1);

        // Flush with 0 and 1 waiting: no grant, ptr back to 0, both served afterwards.
        cyc(0, 1, 4'b0011, 4'b0000, 0, 1, 5'd17, 32'hA000_0001, 2'd1);
        cyc(0, 0, 4'b0011, 4'b0001, 0, 0, 5'd0, 32'h0, 2'd0);
        cyc(0, 0, 4'b0010, 4'b0010, 1, 1, 5'd16, 32'hA000_0000, 2'd0);
        cyc(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd17, 32'hA000_0001, 2'd1);

        // Broadcast registered before a flush stays visible during it.
        cyc(0, 0, 4'b0100, 4'b0100, 0, 0, 5'd0, 32'h0, 2'd0);
        cyc(0, 1, 4'b1000, 4'b0000, 1, 1, 5'd18, 32'hA000_0002, 2'd2);
        cyc(0, 0, 4'b1000, 4'b1000, 0, 0, 5'd0, 32'h0, 2'd0);
        cyc(0, 0, 4'b0000, 4'b0000, 1, 1, 5'd19, 32'hA000_0003, 2'd3);

        // Three contenders for 10 cycles, then a flush; counter survives flush, cleared by rst.
        cyc(1, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'h0, 2'd0);
        for (int k = 0; k < 10; k++) begin
            int s;
            s = (k + 2) % 3;
            cyc_s(0, 0, 4'b0111, 4'(1 << (k % 3)), (k > 0), 1'b1,
                  (k > 0) ? 5'(16 + s) : 5'd0,
                  (k > 0) ? 32'hA000_0000 + 32'(s) : 32'h0,
                  (k > 0) ? 2'(s) : 2'd0, 1'b1, 32'(k));
        end
        cyc_s(0, 1, 4'b0111, 4'b0000, 1, 1, 5'd16, 32'hA000_0000, 2'd0, 1'b1, 32'd10);
        cyc_s(0, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'h0, 2'd0, 1'b1, 32'd10);
        cyc_s(1, 0, 4'b0000, 4'b0000, 0, 0, 5'd0, 32'h0, 2'd0, 1'b1, 32'd10);
        cyc_s(0, 0, 4'b0000, 4'b0000, 0, 1, 5'd0, 32'h0, 2'd0, 1'b1, 32'd0);

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
